serial_word_compare: RTL and testbench

Bit-serial counterpart of the team's parallel 2-bit and 16-bit equality comparators. It accepts two WIDTH-bit words on a start pulse and compares them one bit per clock, LSB first. After a fixed WIDTH-cycle latency it reports equal, less-than and greater-than (unsigned). It is the area-minimal comparator used where a full-width XOR tree is not wanted, and it doubles as a cross-check against the parallel comparators in lab benches.

---
 rtl/serial_word_compare_pkg.sv | 12 +
 rtl/serial_word_compare_if.sv | 23 ++
 rtl/serial_word_compare_bit_cell.sv | 27 ++
 rtl/serial_word_compare.sv | 98 +++++++++
 tb/tb_serial_word_compare.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/serial_word_compare_pkg.sv
// Shared types and defaults for the bit-serial word comparator.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } cmp_state_t;

  localparam int DEFAULT_WIDTH = 16;

endpackage

// File: rtl/serial_word_compare_if.sv
// Request/result bundle of the serial comparator; master drives operands.
interface serial_word_compare_if #(
  parameter int WIDTH = serial_cmp_pkg::DEFAULT_WIDTH
);
  logic             start_in;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy_out;
  logic             done_out;
  logic             eq_out;
  logic             lt_out;
  logic             gt_out;

  modport master (
    output start_in, a_in, b_in,
    input  busy_out, done_out, eq_out, lt_out, gt_out
  );

  modport slave (
    input  start_in, a_in, b_in,
    output busy_out, done_out, eq_out, lt_out, gt_out
  );
endinterface

// File: rtl/serial_word_compare_bit_cell.sv
// One comparator bit: a differing bit decides the order and overrides
// whatever the less significant bits concluded. Also usable as a ripple
// stage in a parallel comparator.
module cmp_bit_cell (
  input  logic a,
  input  logic b,
  input  logic eq_i,
  input  logic lt_i,
  input  logic gt_i,
  output logic eq_o,
  output logic lt_o,
  output logic gt_o
);

  // equal bits pass the running decision through untouched
  always_comb begin
    eq_o = eq_i;
    lt_o = lt_i;
    gt_o = gt_i;
    if (a != b) begin
      eq_o = 1'b0;
      lt_o = ~a & b;
      gt_o = a & ~b;
    end
  end

endmodule

// File: rtl/serial_word_compare.sv
// Bit-serial unsigned comparator: one bit per clock, LSB first, result
// after exactly WIDTH cycles. Results hold until the next completed compare.
//
//   state | meaning
//   IDLE  | waiting for start_in
//   SHIFT | comparing one bit per cycle, start_in ignored
//   DONE  | result just registered; start_in restarts immediately
module serial_word_compare
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_word_compare_if.slave  bus
);

  cmp_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic             eq_w, lt_w, gt_w;
  logic             eq_c, lt_c, gt_c;
  logic             eq_r, lt_r, gt_r;
  logic             accept, last_bit;

  assign accept   = bus.start_in && (state_q != SHIFT);
  assign last_bit = (state_q == SHIFT) && (cnt_q == CNT_W'(WIDTH - 1));

  cmp_bit_cell u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .eq_i (eq_w),
    .lt_i (lt_w),
    .gt_i (gt_w),
    .eq_o (eq_c),
    .lt_o (lt_c),
    .gt_o (gt_c)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start_in) state_d = SHIFT;
      SHIFT:   if (last_bit)     state_d = DONE;
      DONE:    state_d = bus.start_in ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // operand load, bit-serial shift and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      cnt_q <= '0;
      eq_w  <= 1'b0;
      lt_w  <= 1'b0;
      gt_w  <= 1'b0;
      eq_r  <= 1'b0;
      lt_r  <= 1'b0;
      gt_r  <= 1'b0;
    end else if (accept) begin
      a_sr  <= bus.a_in;
      b_sr  <= bus.b_in;
      cnt_q <= '0;
      eq_w  <= 1'b1;
      lt_w  <= 1'b0;
      gt_w  <= 1'b0;
    end else if (state_q == SHIFT) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      cnt_q <= cnt_q + CNT_W'(1);
      eq_w  <= eq_c;
      lt_w  <= lt_c;
      gt_w  <= gt_c;
      if (last_bit) begin
        eq_r <= eq_c;
        lt_r <= lt_c;
        gt_r <= gt_c;
      end
    end
  end

  assign bus.busy_out = (state_q == SHIFT);
  assign bus.done_out = (state_q == DONE);
  assign bus.eq_out   = eq_r;
  assign bus.lt_out   = lt_r;
  assign bus.gt_out   = gt_r;

endmodule

// File: tb/tb_serial_word_compare.sv
// Bench for the serial comparator: directed vectors, multi-cycle corner
// sequences, and a random sweep at WIDTH=16 and WIDTH=5.
module tb_serial_word_compare;
  import serial_cmp_pkg::*;

  localparam int W16 = 16;
  localparam int W5  = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_word_compare_if #(.WIDTH(W16)) bus16 ();
  serial_word_compare_if #(.WIDTH(W5))  bus5 ();

  serial_word_compare #(.WIDTH(W16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  serial_word_compare #(.WIDTH(W5))  dut5  (.clk(clk), .rst(rst), .bus(bus5));

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  exp_elg;   // {eq, lt, gt}
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // reference: plain unsigned relation of the whole words
  function automatic logic [2:0] ref_elg(input logic [63:0] a, input logic [63:0] b);
    if (a == b)     return 3'b100;
    else if (a < b) return 3'b010;
    else            return 3'b001;
  endfunction

  function automatic logic [2:0] elg16();
    return {bus16.eq_out, bus16.lt_out, bus16.gt_out};
  endfunction

  function automatic logic [2:0] elg5();
    return {bus5.eq_out, bus5.lt_out, bus5.gt_out};
  endfunction

  // called at a negedge; returns at the negedge after the accepting edge
  task automatic start16(input logic [15:0] a, input logic [15:0] b);
    bus16.start_in = 1'b1;
    bus16.a_in     = a;
    bus16.b_in     = b;
    @(posedge clk);
    @(negedge clk);
    bus16.start_in = 1'b0;
    bus16.a_in     = ~a;    // changes during SHIFT must not matter
    bus16.b_in     = ~b;
  endtask

  task automatic start5(input logic [4:0] a, input logic [4:0] b);
    bus5.start_in = 1'b1;
    bus5.a_in     = a;
    bus5.b_in     = b;
    @(posedge clk);
    @(negedge clk);
    bus5.start_in = 1'b0;
    bus5.a_in     = ~a;
    bus5.b_in     = ~b;
  endtask

  // n = edges after the accepting edge until done_out seen; bz = busy samples
  task automatic wait_done16(output int n, output int bz);
    n  = 0;
    bz = 0;
    while (!bus16.done_out && n < 100) begin
      if (bus16.busy_out) bz++;
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    if (!bus16.done_out) chk("timeout16", 0, 1);
  endtask

  task automatic wait_done5(output int n);
    n = 0;
    while (!bus5.done_out && n < 100) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    if (!bus5.done_out) chk("timeout5", 0, 1);
  endtask

  initial begin
    int n, bz, dones, first_done;
    logic [15:0] ra, rb;
    logic [4:0]  sa, sb;

    vecs[0] = '{16'h1234, 16'h1234, 3'b100};
    vecs[1] = '{16'h8000, 16'h7FFF, 3'b001};
    vecs[2] = '{16'h0001, 16'h0002, 3'b010};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 3'b100};
    vecs[4] = '{16'h0000, 16'h0000, 3'b100};
    vecs[5] = '{16'h5555, 16'hAAAA, 3'b010};
    vecs[6] = '{16'hFFFF, 16'h0000, 3'b001};
    vecs[7] = '{16'h7FFF, 16'h8000, 3'b010};

    rst = 1'b1;
    bus16.start_in = 1'b0; bus16.a_in = '0; bus16.b_in = '0;
    bus5.start_in  = 1'b0; bus5.a_in  = '0; bus5.b_in  = '0;
    #12;
    chk("reset_outputs", {bus16.busy_out, bus16.done_out, elg16()}, 5'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", {bus16.busy_out, bus16.done_out, elg16()}, 5'b0);

    // directed table
    for (int i = 0; i < 8; i++) begin
      start16(vecs[i].a, vecs[i].b);
      wait_done16(n, bz);
      chk($sformatf("vec%0d_latency", i), n, W16);
      chk($sformatf("vec%0d_busy", i), bz, W16);
      chk($sformatf("vec%0d_flags", i), elg16(), vecs[i].exp_elg);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), {bus16.done_out, bus16.busy_out}, 2'b00);
      chk($sformatf("vec%0d_hold", i), elg16(), vecs[i].exp_elg);
    end

    // back-to-back with start held during DONE
    start16(16'h0001, 16'h0000);
    wait_done16(n, bz);
    chk("b2b_first_flags", elg16(), 3'b001);
    start16(16'h0000, 16'h0001);
    chk("b2b_restart_state", {bus16.busy_out, bus16.done_out}, 2'b10);
    chk("b2b_result_held", elg16(), 3'b001);
    wait_done16(n, bz);
    chk("b2b_spacing", n + 1, W16 + 1);
    chk("b2b_never_idle", bz, W16);
    chk("b2b_second_flags", elg16(), 3'b010);
    @(negedge clk);

    // start during SHIFT is ignored
    start16(16'hFFFF, 16'hFFFE);
    dones = 0;
    first_done = -1;
    for (int i = 0; i < 30; i++) begin
      if (bus16.done_out) begin
        dones++;
        if (first_done < 0) begin
          first_done = i;
          chk("ignore_flags", elg16(), 3'b001);
        end
      end
      if (i == 5) begin
        bus16.start_in = 1'b1;
        bus16.a_in = 16'h0000;
        bus16.b_in = 16'hFFFF;
      end else begin
        bus16.start_in = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
    end
    chk("ignore_done_count", dones, 1);
    chk("ignore_done_time", first_done, W16);

    // reset mid-SHIFT aborts with no done pulse
    start16(16'h0000, 16'hFFFF);
    repeat (7) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("abort_pre_busy", bus16.busy_out, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("abort_async_outputs", {bus16.busy_out, bus16.done_out, elg16()}, 5'b0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      if (bus16.done_out || bus16.busy_out) dones++;
      @(posedge clk);
      @(negedge clk);
    end
    chk("abort_no_done", dones, 0);
    start16(16'h0000, 16'hFFFF);
    wait_done16(n, bz);
    chk("abort_then_lt", elg16(), 3'b010);
    @(negedge clk);

    // random sweep, WIDTH=16, back-to-back
    for (int i = 0; i < 2000; i++) begin
      ra = 16'($urandom);
      rb = (i % 8 == 0) ? ra : 16'($urandom);
      start16(ra, rb);
      wait_done16(n, bz);
      chk($sformatf("rnd16_%0d a=%0h b=%0h", i, ra, rb), elg16(), ref_elg(64'(ra), 64'(rb)));
      chk("rnd16_onehot", $countones(elg16()), 1);
    end

    // random sweep, WIDTH=5
    @(negedge clk);
    for (int i = 0; i < 3000; i++) begin
      sa = 5'($urandom);
      sb = (i % 6 == 0) ? sa : 5'($urandom);
      start5(sa, sb);
      wait_done5(n);
      if (i < 4) chk("rnd5_latency", n, W5);
      chk($sformatf("rnd5_%0d a=%0h b=%0h", i, sa, sb), elg5(), ref_elg(64'(sa), 64'(sb)));
      chk("rnd5_onehot", $countones(elg5()), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
